// File: rtl/put_fsm.sv
// rtl/put_fsm.sv - PUT sub-FSM: snapshot occupancy, pick lowest free entry, write it, report done/error.

package ctrl_types_pkg;
  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;
endpackage

module put_fsm
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   enter,
  input  logic [NUM_ENTRIES-1:0] used,
  output logic [NUM_ENTRIES-1:0] idx_out,
  output logic                   write_out,
  output sub_cmd_t               cmd
);

  typedef enum logic [2:0] {
    PS_IDLE  = 3'd0,
    PS_ALLOC = 3'd1,
    PS_WRITE = 3'd2,
    PS_DONE  = 3'd3,
    PS_ERR   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_ENTRIES-1:0] snap_q, snap_d;
  logic [NUM_ENTRIES-1:0] idx_q, idx_d;
  logic [NUM_ENTRIES-1:0] lowest_free;
  logic                   found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PS_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
    end
  end

  // One-hot of the lowest-index zero bit of the snapshot; all zero when full.
  always_comb begin
    lowest_free = '0;
    found       = 1'b0;
    for (int j = 0; j < NUM_ENTRIES; j++) begin
      if (!found && !snap_q[j]) begin
        lowest_free[j] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    if (enter) begin
      state_d = PS_ALLOC;
      snap_d  = used;
    end else begin
      case (state_q)
        PS_IDLE:  state_d = PS_IDLE;
        PS_ALLOC: begin
          if (!en) begin
            state_d = PS_IDLE;
          end else if (&snap_q) begin
            state_d = PS_ERR;
          end else begin
            idx_d   = lowest_free;
            state_d = PS_WRITE;
          end
        end
        PS_WRITE: state_d = en ? PS_DONE : PS_IDLE;
        PS_DONE:  state_d = PS_IDLE;
        PS_ERR:   state_d = PS_IDLE;
        default:  state_d = PS_IDLE;
      endcase
    end
  end

  // An aborting controller (en=0) sees no strobes even in the cycle it drops en.
  always_comb begin
    write_out = 1'b0;
    idx_out   = '0;
    cmd       = '0;
    case (state_q)
      PS_WRITE: begin
        write_out = en;
        idx_out   = en ? idx_q : '0;
      end
      PS_DONE: cmd.done  = en;
      PS_ERR:  cmd.error = en;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_put_fsm.sv
// tb/tb_put_fsm.sv - directed self-checking bench for put_fsm.

module tb_put_fsm;
  import ctrl_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, enter;
  logic [15:0] used;
  logic [15:0] idx_out;
  logic        write_out;
  sub_cmd_t    cmd;

  logic        en1, enter1;
  logic [0:0]  used1;
  logic [0:0]  idx_out1;
  logic        write_out1;
  sub_cmd_t    cmd1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  put_fsm #(.NUM_ENTRIES(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .used(used),
    .idx_out(idx_out), .write_out(write_out), .cmd(cmd)
  );

  put_fsm #(.NUM_ENTRIES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .enter(enter1), .used(used1),
    .idx_out(idx_out1), .write_out(write_out1), .cmd(cmd1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; enter = 1'b1; used = 16'h0000;
    en1 = 1'b1; enter1 = 1'b0; used1 = 1'b0;
    tick(); tick();
    total++;
    if ({write_out, idx_out, cmd} !== 19'd0) $display("FAIL reset_during: got %h want 0", {write_out, idx_out, cmd});
    else passed++;
    enter = 1'b0; rst_n = 1'b1;
    tick();
    total++;
    if ({write_out, idx_out, cmd} !== 19'd0) $display("FAIL reset_after: got %h want 0", {write_out, idx_out, cmd});
    else passed++;
  endtask

  // Enter pulse before edge 0; returns with the bench in cycle 1.
  task automatic start(input logic [15:0] u);
    used = u; enter = 1'b1; en = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic test_basic();
    start(16'h00FF);
    total++;
    if ({write_out, idx_out, cmd} !== 19'd0) $display("FAIL basic_c1: got %h want 0", {write_out, idx_out, cmd});
    else passed++;
    tick();
    total++;
    if (write_out !== 1'b1 || idx_out !== 16'h0100 || cmd !== 2'b00)
      $display("FAIL basic_c2: got w=%b idx=%h cmd=%b want w=1 idx=0100 cmd=00", write_out, idx_out, cmd);
    else passed++;
    tick();
    total++;
    if (write_out !== 1'b0 || idx_out !== 16'h0 || cmd.done !== 1'b1 || cmd.error !== 1'b0)
      $display("FAIL basic_c3: got w=%b idx=%h cmd=%b want w=0 idx=0 cmd=10", write_out, idx_out, cmd);
    else passed++;
    tick();
    total++;
    if ({write_out, idx_out, cmd} !== 19'd0) $display("FAIL basic_c4: got %h want 0", {write_out, idx_out, cmd});
    else passed++;
  endtask

  task automatic test_full();
    int wr = 0, dn = 0;
    start(16'hFFFF);
    tick();
    total++;
    if (cmd.error !== 1'b1 || cmd.done !== 1'b0 || write_out !== 1'b0)
      $display("FAIL full_c2: got w=%b cmd=%b want w=0 cmd=01", write_out, cmd);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (write_out === 1'b1) wr++;
      if (cmd.done === 1'b1) dn++;
      if (cmd.error === 1'b1) dn++;
    end
    total++;
    if (wr != 0 || dn != 0) $display("FAIL full_after: got writes=%0d strobes=%0d want 0 0", wr, dn);
    else passed++;
  endtask

  task automatic test_boundaries();
    start(16'h7FFF); tick();
    total++;
    if (write_out !== 1'b1 || idx_out !== 16'h8000) $display("FAIL top_idx: got w=%b idx=%h want w=1 idx=8000", write_out, idx_out);
    else passed++;
    tick(); tick();
    start(16'h0000); tick();
    total++;
    if (write_out !== 1'b1 || idx_out !== 16'h0001) $display("FAIL bottom_idx: got w=%b idx=%h want w=1 idx=0001", write_out, idx_out);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_snapshot();
    start(16'h0001);
    used = 16'h0003;
    tick();
    total++;
    if (write_out !== 1'b1 || idx_out !== 16'h0002) $display("FAIL snapshot: got w=%b idx=%h want w=1 idx=0002", write_out, idx_out);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_abort_restart();
    int bad = 0;
    start(16'h0000);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (write_out !== 1'b0 || cmd !== 2'b00) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL abort: got %0d strobe cycles want 0", bad);
    else passed++;
    en = 1'b1;
    start(16'h000F);
    enter = 1'b1; used = 16'h001F;
    tick();
    enter = 1'b0;
    total++;
    if (write_out !== 1'b0) $display("FAIL restart_c2: got w=%b want 0", write_out);
    else passed++;
    tick();
    total++;
    if (write_out !== 1'b1 || idx_out !== 16'h0020) $display("FAIL restart_c3: got w=%b idx=%h want w=1 idx=0020", write_out, idx_out);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    start(16'h0000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if ({write_out, idx_out, cmd} !== 19'd0) bad++;
    for (int i = 0; i < 2; i++) begin
      tick();
      if ({write_out, idx_out, cmd} !== 19'd0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL mid_reset: got %0d active cycles want 0", bad);
    else passed++;
    start(16'h0003); tick();
    total++;
    if (write_out !== 1'b1 || idx_out !== 16'h0004) $display("FAIL post_reset: got w=%b idx=%h want w=1 idx=0004", write_out, idx_out);
    else passed++;
    tick();
    total++;
    if (cmd.done !== 1'b1) $display("FAIL post_reset_done: got %b want 1", cmd.done);
    else passed++;
    tick();
  endtask

  task automatic test_single_entry();
    used1 = 1'b1; enter1 = 1'b1;
    tick();
    enter1 = 1'b0;
    tick();
    total++;
    if (cmd1.error !== 1'b1 || write_out1 !== 1'b0) $display("FAIL n1_full: got err=%b w=%b want 1 0", cmd1.error, write_out1);
    else passed++;
    tick();
    used1 = 1'b0; enter1 = 1'b1;
    tick();
    enter1 = 1'b0;
    tick();
    total++;
    if (write_out1 !== 1'b1 || idx_out1 !== 1'b1) $display("FAIL n1_empty: got w=%b idx=%b want 1 1", write_out1, idx_out1);
    else passed++;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_boundaries();
    test_snapshot();
    test_abort_restart();
    test_mid_reset();
    test_single_entry();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
